// File: rtl/ftoi_cy.sv
// ftoi_cy: two-stage IEEE-754 single-precision to signed 32-bit integer converter.
// Stage 1 classifies and aligns the operand; stage 2 rounds, applies the sign and registers y.
// Optional macro FTOI_FLAGS_EN adds the registered flag_nv / flag_nx outputs.
module ftoi_cy (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        rm,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FTOI_FLAGS_EN
  ,
  output logic        flag_nv,
  output logic        flag_nx
`endif
);

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_SAT_POS,
    CLS_SAT_NEG
  } cls_e;

  logic        advance;

  logic        x_sign;
  logic [7:0]  x_exp;
  logic [22:0] x_man;
  logic [23:0] m24;

  cls_e        dec_cls;
  logic [31:0] dec_mag;
  logic        dec_guard;
  logic        dec_sticky;
  logic [4:0]  dec_sh;
  logic [47:0] dec_shifted;

  logic        s1_valid_q,  s1_valid_d;
  cls_e        s1_cls_q,    s1_cls_d;
  logic        s1_sign_q,   s1_sign_d;
  logic [31:0] s1_mag_q,    s1_mag_d;
  logic        s1_guard_q,  s1_guard_d;
  logic        s1_sticky_q, s1_sticky_d;
  logic        s1_rm_q,     s1_rm_d;

  logic        rnd_inc;
  logic [31:0] rnd_mag;
  logic [31:0] res;

  logic [31:0] y_q,         y_d;
  logic        out_valid_q, out_valid_d;

`ifdef FTOI_FLAGS_EN
  logic        dec_nv;
  logic        s1_nv_q,     s1_nv_d;
  logic        flag_nv_q,   flag_nv_d;
  logic        flag_nx_q,   flag_nx_d;
`endif

  // The whole pipe moves together; it only freezes when a finished result is not taken.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign x_sign = x[31];
  assign x_exp  = x[30:23];
  assign x_man  = x[22:0];
  assign m24    = {1'b1, x_man};

  // Stage 1 decode: classify the operand and align the mantissa into integer position with guard/sticky.
  always_comb begin
    dec_cls     = CLS_NUM;
    dec_mag     = '0;
    dec_guard   = 1'b0;
    dec_sticky  = 1'b0;
    dec_sh      = '0;
    dec_shifted = '0;
`ifdef FTOI_FLAGS_EN
    dec_nv      = 1'b0;
`endif
    if (x_exp == 8'd255) begin
      dec_cls = (x_man != '0) ? CLS_SAT_POS : (x_sign ? CLS_SAT_NEG : CLS_SAT_POS);
`ifdef FTOI_FLAGS_EN
      dec_nv  = 1'b1;
`endif
    end else if (x_exp >= 8'd158) begin
      dec_cls = x_sign ? CLS_SAT_NEG : CLS_SAT_POS;
`ifdef FTOI_FLAGS_EN
      dec_nv  = !(x_sign && (x_exp == 8'd158) && (x_man == '0));
`endif
    end else if (x_exp == 8'd0) begin
      dec_sticky = |x_man;
    end else if (x_exp <= 8'd125) begin
      dec_sticky = 1'b1;
    end else if (x_exp >= 8'd150) begin
      dec_mag = {8'b0, m24} << (x_exp - 8'd150);
    end else begin
      dec_sh      = 5'(8'd150 - x_exp);
      dec_shifted = {m24, 24'b0} >> dec_sh;
      dec_mag     = {8'b0, dec_shifted[47:24]};
      dec_guard   = dec_shifted[23];
      dec_sticky  = |dec_shifted[22:0];
    end
  end

  // Stage 2 datapath: round-to-nearest-even or truncate, then negate; saturation classes bypass rounding.
  always_comb begin
    rnd_inc = !s1_rm_q && s1_guard_q && (s1_sticky_q || s1_mag_q[0]);
    rnd_mag = s1_mag_q + {31'b0, rnd_inc};
    case (s1_cls_q)
      CLS_SAT_POS: res = 32'h7FFF_FFFF;
      CLS_SAT_NEG: res = 32'h8000_0000;
      default:     res = s1_sign_q ? (32'd0 - rnd_mag) : rnd_mag;
    endcase
  end

  // Next-state for both stages: hold everything on a stall, shift on advance; bubbles leave y untouched.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cls_d    = s1_cls_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_rm_d     = s1_rm_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
`ifdef FTOI_FLAGS_EN
    s1_nv_d     = s1_nv_q;
    flag_nv_d   = flag_nv_q;
    flag_nx_d   = flag_nx_q;
`endif
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_cls_d    = dec_cls;
      s1_sign_d   = x_sign;
      s1_mag_d    = dec_mag;
      s1_guard_d  = dec_guard;
      s1_sticky_d = dec_sticky;
      s1_rm_d     = rm;
      out_valid_d = s1_valid_q;
`ifdef FTOI_FLAGS_EN
      s1_nv_d     = dec_nv;
`endif
      if (s1_valid_q) begin
        y_d = res;
`ifdef FTOI_FLAGS_EN
        flag_nv_d = s1_nv_q;
        flag_nx_d = (s1_guard_q || s1_sticky_q) && !s1_nv_q;
`endif
      end
    end
  end

  // Pipeline registers; reset discards anything in flight regardless of the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cls_q    <= CLS_NUM;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_rm_q     <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
`ifdef FTOI_FLAGS_EN
      s1_nv_q     <= 1'b0;
      flag_nv_q   <= 1'b0;
      flag_nx_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cls_q    <= s1_cls_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_rm_q     <= s1_rm_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
`ifdef FTOI_FLAGS_EN
      s1_nv_q     <= s1_nv_d;
      flag_nv_q   <= flag_nv_d;
      flag_nx_q   <= flag_nx_d;
`endif
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
`ifdef FTOI_FLAGS_EN
  assign flag_nv   = flag_nv_q;
  assign flag_nx   = flag_nx_q;
`endif

endmodule

// File: tb/tb_ftoi_cy.sv
// tb_ftoi_cy: directed and randomized checks of ftoi_cy against an arithmetic reference model.
module tb_ftoi_cy;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        rm;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
`ifdef FTOI_FLAGS_EN
  logic        flag_nv;
  logic        flag_nx;
`endif

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   outCount = 0;
  exp_t sb[$];
  exp_t pendingExp;
  logic        held = 1'b0;
  logic [31:0] heldY = '0;

  ftoi_cy dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .rm        (rm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FTOI_FLAGS_EN
    ,
    .flag_nv   (flag_nv),
    .flag_nx   (flag_nx)
`endif
  );

  always #5 clk = ~clk;

  // Exact value is mantissa * 2^(e-150); round by comparing the dropped remainder with one half.
  function automatic exp_t refModel(logic [31:0] fx, logic frm);
    exp_t   r;
    int     e;
    int     sh;
    logic   s;
    longint m, ip, rem, half, mag;
    r   = '0;
    s   = fx[31];
    e   = int'(fx[30:23]);
    m   = longint'({1'b1, fx[22:0]});
    rem = 0;
    if (e == 255 && fx[22:0] != 23'd0) begin
      r.y  = 32'h7FFF_FFFF;
      r.nv = 1'b1;
    end else if (e >= 158) begin
      r.y  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r.nv = !(s && e == 158 && fx[22:0] == 23'd0);
    end else if (e == 0) begin
      r.nx = (fx[22:0] != 23'd0);
    end else if (e <= 125) begin
      r.nx = 1'b1;
    end else begin
      if (e >= 150) begin
        mag = m << (e - 150);
      end else begin
        sh   = 150 - e;
        ip   = m >> sh;
        rem  = m - (ip << sh);
        half = longint'(1) << (sh - 1);
        mag  = ip;
        if (!frm && (rem > half || (rem == half && ip[0]))) mag = mag + 1;
      end
      r.y  = s ? 32'(-mag) : 32'(mag);
      r.nx = (rem != 0);
    end
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] fx, logic frm, exp_t e);
    in_valid   = v;
    x          = fx;
    rm         = frm;
    pendingExp = e;
  endtask

  // One cycle, starting and ending at a falling edge: check outputs, update scoreboard, clock.
  task automatic stepCycle(output logic accepted);
    exp_t e;
    #1;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
    if (held) begin
      checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_y", y, heldY);
    end
    if (out_valid && out_ready) begin
      outCount++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_out: observed y=%h with no result outstanding", y);
      end else begin
        e = sb.pop_front();
        checkOutput("y", y, e.y);
`ifdef FTOI_FLAGS_EN
        checkOutput("flag_nv", {31'b0, flag_nv}, {31'b0, e.nv});
        checkOutput("flag_nx", {31'b0, flag_nx}, {31'b0, e.nx});
`endif
      end
    end
    held     = out_valid && !out_ready;
    heldY    = y;
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(pendingExp);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] randFloat();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 1) v[30:23] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
    else if (sel >= 2) v[30:23] = 8'($urandom_range(120, 160));
    if (sel == 9) v[22:0] = ($urandom_range(0, 1) == 1) ? 23'h400000 : 23'h0;
    return v;
  endfunction

  logic [31:0] dirX  [13] = '{32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h402CCCCD,
                              32'h3F000000, 32'h4F000000, 32'hCF000000, 32'h4EFFFFFF,
                              32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h3FC00000,
                              32'h7F800000};
  logic        dirRm [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] dirY  [13] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'h00000002,
                              32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80,
                              32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000001,
                              32'h7FFFFFFF};
  logic        dirNv [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        dirNx [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic        acc;
    int          idx;
    int          cyc;
    int          startCount;
    logic [31:0] v;
    logic        r;
    exp_t        e;

    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_y", y, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    $display("[TB] directed rounding and boundary vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, dirX[i], dirRm[i], '{y: dirY[i], nv: dirNv[i], nx: dirNx[i]});
      stepCycle(acc);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, '0);
    for (int i = 0; i < 4; i++) stepCycle(acc);
    checkOutput("directed_drained", 32'(sb.size()), 32'd0);

    $display("[TB] latency");
    e = refModel(32'h42F60000, 1'b0);
    applyStimulus(1'b1, 32'h42F60000, 1'b0, e);
    stepCycle(acc);
    applyStimulus(1'b0, 32'h0, 1'b0, '0);
    #1;
    checkOutput("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    stepCycle(acc);
    #1;
    checkOutput("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("lat_n2_y", y, 32'd123);
    stepCycle(acc);
    #1;
    checkOutput("lat_n3_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] back-pressure stream");
    startCount = outCount;
    idx = 0;
    cyc = 0;
    v = randFloat();
    r = 1'($urandom_range(0, 1));
    while ((outCount - startCount < 8) && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (idx < 8) applyStimulus(1'b1, v, r, refModel(v, r));
      else applyStimulus(1'b0, 32'h0, 1'b0, '0);
      stepCycle(acc);
      if (acc) begin
        idx++;
        v = randFloat();
        r = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    checkOutput("bp_count", 32'(outCount - startCount), 32'd8);
    checkOutput("bp_drained", 32'(sb.size()), 32'd0);

    $display("[TB] randomized traffic");
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      v = randFloat();
      r = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 4) != 0), v, r, refModel(v, r));
      stepCycle(acc);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle(acc);
    checkOutput("rand_drained", 32'(sb.size()), 32'd0);

    $display("[TB] reset with full pipe");
    out_ready = 1'b0;
    v = 32'h41200000;
    applyStimulus(1'b1, v, 1'b0, refModel(v, 1'b0));
    stepCycle(acc);
    stepCycle(acc);
    applyStimulus(1'b0, 32'h0, 1'b0, '0);
    #1;
    checkOutput("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_reset_y", y, 32'd0);
    sb.delete();
    held = 1'b0;
    out_ready = 1'b1;
    startCount = outCount;
    for (int i = 0; i < 5; i++) stepCycle(acc);
    checkOutput("no_stale_out", 32'(outCount - startCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftoi_cy.md
Name: ftoi_cy

Overview:
- Pipelined IEEE-754 single-precision float to signed 32-bit integer converter for the FPU.
- It is the reverse path of the FPU float datapath: it decodes the float format produced by the adder and multiplier back into the integer domain.
- It sits between the FPU issue logic and integer writeback, with a valid/ready handshake on both sides.
- Fixed latency is 2 cycles when not stalled; throughput is 1 conversion per cycle.

Parameters:
- None. All widths are fixed by the single-precision and 32-bit integer formats.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- x  input  32  float operand {sign, exp[7:0], man[22:0]}
- rm  input  1  rounding mode: 0 = round-to-nearest-even, 1 = truncate toward zero
- in_valid  input  1  x and rm are valid this cycle
- in_ready  output  1  converter accepts x this cycle
- y  output  32  signed two's-complement result
- out_valid  output  1  y is valid
- out_ready  input  1  consumer accepts y this cycle

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all valid bits 0, y = 0. Internal stage registers are also 0.
- Pipeline structure:
  - Stage 1 register (s1): classification, sign, aligned 32-bit magnitude, guard bit, sticky bit, rm.
  - Stage 2 register: output y and out_valid.
- Handshake and stalls:
  - advance = !out_valid || out_ready. in_ready = advance (combinational).
  - When advance = 1, both stages shift: s1 loads (in_valid, x), output loads s1. An input transfer occurs on in_valid && in_ready.
  - When advance = 0, all registers hold. y must stay stable while out_valid && !out_ready.
  - A bubble in s1 loads out_valid = 0; y may hold its old value.
- Classification in stage 1 (e = x[30:23]):
  - e == 255 and man != 0 (NaN): result 0x7FFFFFFF.
  - e == 255 and man == 0 (Inf): +Inf gives 0x7FFFFFFF, -Inf gives 0x80000000.
  - e >= 158 (|x| >= 2^31): saturate by sign, positive 0x7FFFFFFF, negative 0x80000000. Note -2^31 (0xCF000000) is exact.
  - e == 0 (zero or denormal): magnitude 0. Treat a nonzero mantissa as sticky only.
  - e <= 125: magnitude 0, guard 0, sticky 1 (|x| < 0.5).
- Alignment for 126 <= e <= 157:
  - m24 = {1, man}.
  - If e >= 150: magnitude = m24 << (e - 150), guard = sticky = 0.
  - Else sh = 150 - e (1..24): magnitude = m24 >> sh, guard = bit sh-1 of m24, sticky = OR of m24 bits below sh-1.
- Rounding in stage 2:
  - rm = 1: no increment.
  - rm = 0: increment when guard && (sticky || magnitude[0]).
  - The rounding increment cannot overflow 2^31-1: the largest float below 2^31 is an integer.
- Sign and saturation in stage 2:
  - Result is -magnitude when sign = 1, else magnitude.
  - A result of 0 is always 0x00000000; no negative zero.
  - Saturation and NaN classes bypass rounding.
- Reset mid-operation: rst overrides any handshake state in the same edge. In-flight conversions are discarded and out_valid = 0 on the next cycle.
- Simultaneous events: out_ready && in_valid with a full pipe gives a full-rate transfer with no bubble.

Optional Feature:
- Macro: FTOI_FLAGS_EN.
- Defined: adds output ports flag_nv (1 bit) and flag_nx (1 bit). Both are registered alongside y, valid with out_valid, and reset to 0.
  - flag_nv = 1 for NaN, Inf, or saturation, except exact -2^31.
  - flag_nx = 1 when guard || sticky and flag_nv = 0.
- Undefined: the ports are absent and no flag logic is synthesized.

Test Plan:
- Rounding, RNE and truncate:
  - 0x3FC00000 (1.5), rm=0 -> 0x00000002.
  - 0x40200000 (2.5), rm=0 -> 0x00000002.
  - 0xC0200000 (-2.5), rm=0 -> 0xFFFFFFFE.
  - 0x402CCCCD (2.7), rm=1 -> 0x00000002.
  - 0x3F000000 (0.5), rm=0 -> 0x00000000.
- Boundaries:
  - 0x4F000000 -> 0x7FFFFFFF.
  - 0xCF000000 -> 0x80000000 (flag_nv = 0).
  - 0x4EFFFFFF -> 0x7FFFFF80.
  - 0x7FC00000 -> 0x7FFFFFFF.
  - 0xFF800000 -> 0x80000000.
  - 0x00000001 -> 0.
- Latency: in_valid pulse at cycle n with out_ready = 1 -> out_valid high only in cycle n+2, with the correct y.
- Back-pressure: stream 8 operands with out_ready toggling 1,0,0,1,... -> every result appears exactly once and in order, y is stable during stalls, and in_ready = 0 exactly when out_valid && !out_ready.
- Reset: assert rst for one cycle while both stages hold valid data -> out_valid = 0 and y = 0 the next cycle, and no stale result emerges afterwards.
- With FTOI_FLAGS_EN defined:
  - 0x3FC00000, rm=1 -> y = 1, flag_nx = 1.
  - 0x7F800000 -> flag_nv = 1, flag_nx = 0.
